tinker_mem_responder: RTL and testbench
=======================================

# tinker_mem_responder

Memory-side responder for the Tinker core's data port. It accepts one load or store request at a time over a valid/ready request channel and holds a little-endian byte array. After a programmable access latency it returns a response (read data or write acknowledge) over a valid/ready response channel. It replaces the zero-latency data read path when the core's LSU is moved to a handshaked memory interface.

## Interface
Parameters:
- MEM_BYTES, 524288: size of byte array; power of two, ≥ 8.
- LATENCY, 2: cycles from request acceptance to rsp_valid rising; legal range 1–15.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address of the 8-byte access.
- req_wdata  input  64  store data, little-endian.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  64  load data (0 for stores).
- rsp_err  output  1  access rejected (see Configuration).

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE: req_ready=1. On (req_valid && req_ready) at an edge:
  - latch write, addr, wdata;
  - load counter with LATENCY-1;
  - go to BUSY.
  - A store is committed to the array on this same acceptance edge, unless it is flagged as an error.
- BUSY: req_ready=0. Each edge with cnt≠0 decrements cnt. On the edge with cnt==0:
  - capture rsp_rdata and rsp_err;
  - go to RESP.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until handshake. On (rsp_valid && rsp_ready) at an edge, go to IDLE.
- Read data assembly: rsp_rdata = {mem[a+7],…,mem[a]}, where a is the latched address. Loads read the array at the capture edge, so they see every previously committed store.
- Store responses: rsp_rdata=0, rsp_err as computed.
- Byte index width: log2(MEM_BYTES). Addresses are byte-granular and need not be 8-byte aligned.
- Only one request is outstanding at a time. req_* inputs are ignored outside IDLE.
- Array contents are not cleared by reset.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0.
- Acceptance at edge T0 ⇒ rsp_valid=1 in the cycle after edge T0+LATENCY.
- Response handshake at edge T1 ⇒ req_ready=1 in the cycle after T1. The next request can be accepted at edge T1+1.
- Minimum spacing between accepted requests: LATENCY+2 cycles.
- req_ready depends only on state, never on req_valid. rsp_valid depends only on state, never on rsp_ready.
- Reset asserted mid-operation:
  - FSM returns to IDLE immediately and the pending response is discarded;
  - a store already committed at acceptance stays in the array.
- rsp_ready held high continuously: the response is presented for exactly one cycle.

## Configuration
- TINKER_MEM_RANGE_CHECK_EN defined:
  - a request with a+7 ≥ MEM_BYTES, evaluated on the full 64-bit address, sets rsp_err=1 and rsp_rdata=0;
  - an erroring store does not modify the array;
  - response timing is unchanged.
- TINKER_MEM_RANGE_CHECK_EN undefined:
  - rsp_err is tied to 0;
  - each byte index wraps modulo MEM_BYTES, so byte k uses (a+k) mod MEM_BYTES.

## Test plan
- Store/load, LATENCY=2: store 0x1122334455667788 @0x100, then load @0x100 → rsp_rdata=0x1122334455667788, rsp_err=0; mem[0x100]=0x88 and mem[0x107]=0x11; rsp_valid rises 2 cycles after each acceptance.
- Unaligned load: after the store above, load @0x103 → rsp_rdata low byte 0x55 and bits [39:32]=0x11.
- Response backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_rdata and rsp_err are stable and req_ready=0 throughout; req_ready returns 1 the cycle after the handshake.
- Out-of-range store to 0x7FFFC with MEM_BYTES=524288:
  - macro defined → rsp_err=1 and a following load @0 returns its prior value;
  - macro undefined → bytes 0x7FFFC..0x7FFFF and 0..3 are written.
- Reset mid-BUSY: assert reset one cycle after accepting a load → rsp_valid=0 and req_ready=1 immediately; no response appears after reset release.
- Ignored request: pulse req_valid while in BUSY with a different address → no second response, and the first response carries the original address's data.

Source files
------------

// File: rtl/tinker_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tinker_mem_responder
// Purpose  : Memory-side responder for the Tinker core data port. Accepts one
//            8-byte load/store at a time on a valid/ready request channel,
//            holds a little-endian byte array and returns the load data or a
//            store acknowledge after LATENCY cycles on a valid/ready response
//            channel.
// Ports    : clk        - single clock, rising edge
//            reset      - asynchronous reset, active low
//            req_valid  / req_ready  - request handshake
//            req_write  - 1 = store, 0 = load
//            req_addr   - byte address of the 8-byte access (any alignment)
//            req_wdata  - store data, little-endian
//            rsp_valid  / rsp_ready  - response handshake
//            rsp_rdata  - load data (0 for stores and rejected accesses)
//            rsp_err    - access rejected by the range check
// Options  : TINKER_MEM_RANGE_CHECK_EN - when defined, accesses whose last
//            byte lies beyond the array are rejected (rsp_err=1, no write).
//            When undefined, byte indices wrap modulo MEM_BYTES.
// Revision : 1.0 - initial release
// ============================================================================
module tinker_mem_responder #(
    parameter int MEM_BYTES = 524288,  // power of two, >= 8
    parameter int LATENCY   = 2        // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int c_aw = $clog2(MEM_BYTES);

`ifdef TINKER_MEM_RANGE_CHECK_EN
    localparam bit c_range_check = 1'b1;
`else
    localparam bit c_range_check = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [7:0]  mem_q [MEM_BYTES];
    logic        mem_we;
    logic [63:0] rd_word;

    // Evaluated on the full 64-bit address with one extra bit so that
    // addresses near 2^64 cannot wrap around and look in range.
    function automatic logic out_of_range(input logic [63:0] a);
        return c_range_check && (({1'b0, a} + 65'd7) >= 65'(MEM_BYTES));
    endfunction

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Little-endian assembly from the latched address; the c_aw-bit index
    // arithmetic gives the modulo-MEM_BYTES wrap for free.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 8; k++) begin
            rd_word[8*k +: 8] = mem_q[addr_q[c_aw-1:0] + c_aw'(k)];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                    // Stores commit on the acceptance edge so that any
                    // later load observes them regardless of reset.
                    mem_we  = req_write && !out_of_range(req_addr);
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    err_d   = out_of_range(addr_q);
                    rdata_d = (write_q || out_of_range(addr_q)) ? 64'd0 : rd_word;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The array is deliberately outside the reset domain: its contents
    // survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[req_addr[c_aw-1:0] + c_aw'(k)] <= req_wdata[8*k +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tinker_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tinker_mem_responder
// Purpose  : Self-checking bench for tinker_mem_responder. Expected responses
//            come from a byte-array model and are queued at request time,
//            then popped and compared when the response is taken.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tinker_mem_responder;

    localparam int MEM_BYTES = 524288;
    localparam int LATENCY   = 2;

`ifdef TINKER_MEM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [63:0] req_addr  = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [bit [63:0]];

    tinker_mem_responder #(
        .MEM_BYTES (MEM_BYTES),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    // Reference model of one access; updates the model array for stores.
    function automatic exp_t model_access(input logic w, input logic [63:0] a,
                                          input logic [63:0] d);
        exp_t        e;
        logic [63:0] idx;
        e.err   = RANGE_EN && (({1'b0, a} + 65'd7) >= 65'(MEM_BYTES));
        e.rdata = 64'd0;
        for (int k = 0; k < 8; k++) begin
            idx = (a + 64'(k)) & 64'(MEM_BYTES - 1);
            if (!e.err && w)  mdl[idx] = d[8*k +: 8];
            if (!e.err && !w) e.rdata[8*k +: 8] = mdl[idx];
        end
        return e;
    endfunction

    // Called #1 after an edge with the DUT idle; the next edge accepts.
    task automatic send_req(input logic w, input logic [63:0] a, input logic [63:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        sb.push_back(model_access(w, a, d));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 32) begin
            @(posedge clk); #1;
            lat++;
        end
        if (rsp_valid !== 1'b1) lat = -1;
    endtask

    task automatic take_rsp(output logic [63:0] d, output logic e);
        d = rsp_rdata;
        e = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_txn(input logic w, input logic [63:0] a, input logic [63:0] wd,
                           output int lat, output logic [63:0] d, output logic e,
                           output exp_t ex);
        send_req(w, a, wd);
        wait_valid(lat);
        take_rsp(d, e);
        ex = sb.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b required 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        int          lat;
        logic [63:0] d;
        logic        e;
        exp_t        ex;
        run_txn(1'b1, 64'h100, 64'h1122334455667788, lat, d, e, ex);
        checks++;
        if (lat !== LATENCY || d !== ex.rdata || e !== ex.err) begin
            errors++;
            $display("FAIL store_rsp: got lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                     lat, d, e, LATENCY, ex.rdata, ex.err);
        end
        run_txn(1'b0, 64'h100, 64'd0, lat, d, e, ex);
        checks++;
        if (lat !== LATENCY || d !== ex.rdata || e !== ex.err) begin
            errors++;
            $display("FAIL load_rsp: got lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                     lat, d, e, LATENCY, ex.rdata, ex.err);
        end
        checks++;
        if (d !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL load_const: got %h required 1122334455667788", d);
        end
    endtask

    task automatic test_unaligned();
        int          lat;
        logic [63:0] d;
        logic        e;
        exp_t        ex;
        run_txn(1'b1, 64'h108, 64'h99AABBCCDDEEFF00, lat, d, e, ex);
        run_txn(1'b0, 64'h103, 64'd0, lat, d, e, ex);
        checks++;
        if (lat !== LATENCY || d !== ex.rdata || e !== ex.err) begin
            errors++;
            $display("FAIL unaligned_rsp: got lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                     lat, d, e, LATENCY, ex.rdata, ex.err);
        end
        checks++;
        if (d[7:0] !== 8'h55 || d[39:32] !== 8'h11) begin
            errors++;
            $display("FAIL unaligned_bytes: got b0=%h b4=%h required 55 11", d[7:0], d[39:32]);
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        int          bad;
        logic [63:0] d0;
        logic        e0;
        logic [63:0] d;
        logic        e;
        exp_t        ex;
        send_req(1'b0, 64'h100, 64'd0);
        wait_valid(lat);
        d0  = rsp_rdata;
        e0  = rsp_err;
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== d0 || rsp_err !== e0 || req_ready !== 1'b0) bad++;
        end
        checks++;
        if (lat !== LATENCY || bad !== 0) begin
            errors++;
            $display("FAIL backpressure_hold: got lat=%0d unstable=%0d required lat=%0d unstable=0",
                     lat, bad, LATENCY);
        end
        take_rsp(d, e);
        ex = sb.pop_front();
        checks++;
        if (d !== ex.rdata || e !== ex.err) begin
            errors++;
            $display("FAIL backpressure_data: got %h/%b required %h/%b", d, e, ex.rdata, ex.err);
        end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: got ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_rsp_ready_high();
        int          nvalid;
        int          first;
        logic [63:0] d;
        exp_t        ex;
        rsp_ready = 1'b1;
        send_req(1'b0, 64'h100, 64'd0);
        nvalid = 0;
        first  = -1;
        d      = 64'd0;
        for (int i = 1; i <= 10; i++) begin
            if (rsp_valid === 1'b1) begin
                nvalid++;
                if (first < 0) first = i - 1;
                d = rsp_rdata;
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        ex = sb.pop_front();
        checks++;
        if (nvalid !== 1 || first !== LATENCY || d !== ex.rdata) begin
            errors++;
            $display("FAIL ready_high: got cycles=%0d lat=%0d rdata=%h required 1 %0d %h",
                     nvalid, first, d, LATENCY, ex.rdata);
        end
    endtask

    task automatic test_out_of_range();
        int          lat;
        logic [63:0] d;
        logic        e;
        exp_t        ex;
        logic        ow   [5];
        logic [63:0] oa   [5];
        logic [63:0] od   [5];
        ow = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        oa = '{64'h0, 64'h7FFF8, 64'h7FFFC, 64'h0, 64'h7FFF8};
        od = '{64'h0706050403020100, 64'hF7F6F5F4F3F2F1F0, 64'hDEADBEEFCAFEF00D, 64'd0, 64'd0};
        for (int i = 0; i < 5; i++) begin
            run_txn(ow[i], oa[i], od[i], lat, d, e, ex);
            checks++;
            if (lat !== LATENCY || d !== ex.rdata || e !== ex.err) begin
                errors++;
                $display("FAIL oor_%0d: got lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                         i, lat, d, e, LATENCY, ex.rdata, ex.err);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int          nv;
        int          lat;
        logic [63:0] d;
        logic        e;
        exp_t        ex;
        exp_t        dropped;
        for (int c = 0; c < 2; c++) begin
            send_req(c[0], c[0] ? 64'h200 : 64'h100, 64'h0123456789ABCDEF);
            dropped = sb.pop_back();
            @(posedge clk); #1;
            reset = 1'b0;
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_busy_%0d: got valid=%b ready=%b required 0 1",
                         c, rsp_valid, req_ready);
            end
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b1;
            nv = 0;
            repeat (8) begin
                @(posedge clk); #1;
                if (rsp_valid !== 1'b0) nv++;
            end
            checks++;
            if (nv !== 0) begin
                errors++;
                $display("FAIL stale_rsp_%0d: got %0d valid cycles required 0", c, nv);
            end
        end
        run_txn(1'b0, 64'h200, 64'd0, lat, d, e, ex);
        checks++;
        if (lat !== LATENCY || d !== ex.rdata || d !== 64'h0123456789ABCDEF) begin
            errors++;
            $display("FAIL store_survives_reset: got lat=%0d rdata=%h required lat=%0d rdata=%h",
                     lat, d, LATENCY, ex.rdata);
        end
    endtask

    task automatic test_ignored_request();
        int          lat;
        int          nv;
        logic [63:0] d;
        logic        e;
        exp_t        ex;
        send_req(1'b0, 64'h100, 64'd0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h103;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_valid(lat);
        take_rsp(d, e);
        ex = sb.pop_front();
        checks++;
        if (lat !== LATENCY - 1 || d !== ex.rdata || e !== ex.err) begin
            errors++;
            $display("FAIL ignored_req_rsp: got lat=%0d rdata=%h err=%b required lat=%0d rdata=%h err=%b",
                     lat, d, e, LATENCY - 1, ex.rdata, ex.err);
        end
        nv = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL ignored_req_extra: got %0d valid cycles required 0", nv);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_unaligned();
        test_backpressure();
        test_rsp_ready_high();
        test_out_of_range();
        test_reset_mid_busy();
        test_ignored_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
